// File: rtl/ct_spsram_arb_pkg.sv
// Shared constants and types for the 65536x128 single-port SRAM arbiter.
package ct_spsram_arb_pkg;

   localparam int unsigned ADDR_WIDTH = 16;
   localparam int unsigned DATA_WIDTH = 128;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_e;

   typedef struct packed {
      logic                  wr;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
      logic [DATA_WIDTH-1:0] wmask;
   } req_t;

endpackage

// File: rtl/ct_spsram_arb_rr.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to
// the requester rr_ptr selects, and the pointer then moves to the other one.
module ct_spsram_arb_rr (
   input  logic [1:0] vld,
   input  logic       rr_ptr,
   output logic [1:0] grant,
   output logic       rr_ptr_nxt
);

   // Grant selection and next pointer (pointer holds when nothing is granted)
   always_comb begin
      grant      = 2'b00;
      rr_ptr_nxt = rr_ptr;
      case (vld)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
      if (grant[0]) begin
         rr_ptr_nxt = 1'b1;
      end else if (grant[1]) begin
         rr_ptr_nxt = 1'b0;
      end
   end

endmodule

// File: rtl/ct_spsram_65536x128_arb.sv
// Two-requester round-robin controller in front of a 65536x128 single-port
// SRAM. Drives the SRAM's active-low controls combinationally from the
// granted request and returns 1-cycle read data to the issuing requester.
// Define CT_SPSRAM_ARB_INIT_EN to zero-fill the whole array after reset
// before any request is granted.
module ct_spsram_65536x128_arb
   import ct_spsram_arb_pkg::*;
(
   input  logic                  forever_cpuclk,
   input  logic                  cpurst,

   input  logic                  req0_vld,
   input  logic                  req0_wr,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   input  logic [DATA_WIDTH-1:0] req0_wmask,
   output logic                  req0_rdy,
   output logic                  req0_rvld,
   output logic [DATA_WIDTH-1:0] req0_rdata,

   input  logic                  req1_vld,
   input  logic                  req1_wr,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   input  logic [DATA_WIDTH-1:0] req1_wmask,
   output logic                  req1_rdy,
   output logic                  req1_rvld,
   output logic [DATA_WIDTH-1:0] req1_rdata,

   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q,

   output logic                  init_done
);

`ifdef CT_SPSRAM_ARB_INIT_EN
   localparam state_e RST_STATE = ST_INIT;
`else
   localparam state_e RST_STATE = ST_RUN;
`endif

   state_e                state_q, state_d;
   logic                  init_done_q, init_done_d;
`ifdef CT_SPSRAM_ARB_INIT_EN
   logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
`endif

   logic                  rr_ptr_q, rr_ptr_d, rr_ptr_nxt;
   logic [1:0]            rvld_q, rvld_d;
   logic [ADDR_WIDTH-1:0] a_q, a_d;
   logic [DATA_WIDTH-1:0] d_q, d_d;
   logic [DATA_WIDTH-1:0] wen_q, wen_d;

   logic                  run_en;
   logic                  init_wr;
   logic                  acc;
   logic [1:0]            vld_run;
   logic [1:0]            grant;
   logic                  cen, gwen;
   req_t                  req0_s, req1_s, sel;

   assign req0_s = {req0_wr, req0_addr, req0_wdata, req0_wmask};
   assign req1_s = {req1_wr, req1_addr, req1_wdata, req1_wmask};

   // Gating with cpurst keeps every output inactive while reset is held
   assign run_en  = (state_q == ST_RUN) & init_done_q & ~cpurst;
   assign vld_run = {req1_vld, req0_vld} & {2{run_en}};

   ct_spsram_arb_rr u_rr (
      .vld        (vld_run),
      .rr_ptr     (rr_ptr_q),
      .grant      (grant),
      .rr_ptr_nxt (rr_ptr_nxt)
   );

   assign acc = |grant;
   assign sel = grant[1] ? req1_s : req0_s;

   // Sweep progress and RUN entry
   always_comb begin
      state_d     = state_q;
      init_done_d = init_done_q;
`ifdef CT_SPSRAM_ARB_INIT_EN
      init_cnt_d  = init_cnt_q;
      if (state_q == ST_INIT) begin
         init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
         if (init_cnt_q == '1) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
         end
      end
`else
      init_done_d = 1'b1;
`endif
   end

   // SRAM drive: a/d/wen fall back to their held values so idle cycles do not toggle them
   always_comb begin
      init_wr = 1'b0;
`ifdef CT_SPSRAM_ARB_INIT_EN
      init_wr = (state_q == ST_INIT) & ~cpurst;
`endif
      cen   = 1'b1;
      gwen  = 1'b1;
      a_d   = a_q;
      d_d   = d_q;
      wen_d = wen_q;
`ifdef CT_SPSRAM_ARB_INIT_EN
      if (init_wr) begin
         cen   = 1'b0;
         gwen  = 1'b0;
         a_d   = init_cnt_q;
         d_d   = '0;
         wen_d = '0;
      end else
`endif
      if (acc) begin
         cen   = 1'b0;
         gwen  = ~sel.wr;
         a_d   = sel.addr;
         d_d   = sel.wdata;
         wen_d = ~sel.wmask;
      end
      rvld_d   = (acc && !sel.wr) ? grant : 2'b00;
      rr_ptr_d = rr_ptr_nxt;
   end

   // Controller state: sweep counter, state and ready flag
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         state_q     <= RST_STATE;
         init_done_q <= 1'b0;
`ifdef CT_SPSRAM_ARB_INIT_EN
         init_cnt_q  <= '0;
`endif
      end else begin
         state_q     <= state_d;
         init_done_q <= init_done_d;
`ifdef CT_SPSRAM_ARB_INIT_EN
         init_cnt_q  <= init_cnt_d;
`endif
      end
   end

   // Arbitration pointer, read-return tags and held SRAM inputs
   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         rr_ptr_q <= 1'b0;
         rvld_q   <= 2'b00;
         a_q      <= '0;
         d_q      <= '0;
         wen_q    <= '1;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         rvld_q   <= rvld_d;
         a_q      <= a_d;
         d_q      <= d_d;
         wen_q    <= wen_d;
      end
   end

   assign req0_rdy   = grant[0];
   assign req1_rdy   = grant[1];
   assign req0_rvld  = rvld_q[0];
   assign req1_rvld  = rvld_q[1];
   assign req0_rdata = sram_q;
   assign req1_rdata = sram_q;

   assign sram_a    = a_d;
   assign sram_cen  = cen;
   assign sram_gwen = gwen;
   assign sram_wen  = wen_d;
   assign sram_d    = d_d;
   assign init_done = init_done_q;

endmodule
